// File: rtl/truth_table_extractor.sv
// Sweeps every input combination of a small combinational block, waits a
// programmable settle time per combination and captures its 1-bit response.
module truth_table_extractor #(
   parameter int N_IN   = 2,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 abort,
   output logic [N_IN-1:0]      stim,
   input  logic                 resp,
   output logic                 busy,
   output logic                 done,
   output logic                 valid,
   output logic [2**N_IN-1:0]   truth_table
);

   localparam int              DEPTH      = 2**N_IN;
   localparam logic [N_IN:0]   LAST_INDEX = (N_IN+1)'(DEPTH - 1);
   localparam logic [3:0]      SETTLE_CNT = 4'(SETTLE);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_CAPTURE,
      S_FINISH
   } state_t;

   state_t             state_reg, state_next;
   logic [N_IN-1:0]    stim_reg, stim_next;
   logic [N_IN:0]      index_reg, index_next;
   logic [3:0]         cnt_reg, cnt_next;
   logic [DEPTH-1:0]   table_reg, table_next;
   logic [DEPTH-1:0]   shadow_reg;
   logic               done_reg, done_next;
   logic               valid_reg, valid_next;
   logic               clear_shadow;
   logic               capture;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= S_IDLE;
         stim_reg  <= '0;
         index_reg <= '0;
         cnt_reg   <= '0;
         table_reg <= '0;
         done_reg  <= 1'b0;
         valid_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         stim_reg  <= stim_next;
         index_reg <= index_next;
         cnt_reg   <= cnt_next;
         table_reg <= table_next;
         done_reg  <= done_next;
         valid_reg <= valid_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      stim_next    = stim_reg;
      index_next   = index_reg;
      cnt_next     = cnt_reg;
      table_next   = table_reg;
      done_next    = 1'b0;
      valid_next   = valid_reg;
      clear_shadow = 1'b0;
      capture      = 1'b0;

      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next   = S_SETTLE;
               index_next   = '0;
               stim_next    = '0;
               cnt_next     = SETTLE_CNT;
               clear_shadow = 1'b1;
            end
         end
         S_SETTLE: begin
            if (cnt_reg == 4'd0) state_next = S_CAPTURE;
            else                 cnt_next   = cnt_reg - 4'd1;
         end
         S_CAPTURE: begin
            capture = 1'b1;
            if (index_reg == LAST_INDEX) begin
               state_next = S_FINISH;
            end else begin
               index_next = index_reg + (N_IN+1)'(1);
               stim_next  = stim_reg + N_IN'(1);
               cnt_next   = SETTLE_CNT;
               state_next = S_SETTLE;
            end
         end
         S_FINISH: begin
            state_next = S_IDLE;
            table_next = shadow_reg;
            done_next  = 1'b1;
            valid_next = 1'b1;
            stim_next  = '0;
         end
         default: state_next = S_IDLE;
      endcase

      // Abort overrides whatever the active state wanted, including publication.
      if (state_reg != S_IDLE && abort) begin
         state_next = S_IDLE;
         stim_next  = '0;
         table_next = table_reg;
         valid_next = valid_reg;
         done_next  = 1'b0;
         capture    = 1'b0;
      end
   end

   // One flop per table entry, written only when the sweep index selects it.
   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_shadow
         always_ff @(posedge clk) begin
            if (rst || clear_shadow)
               shadow_reg[gi] <= 1'b0;
            else if (capture && index_reg == (N_IN+1)'(gi))
               shadow_reg[gi] <= resp;
         end
      end
   endgenerate

   assign stim        = stim_reg;
   assign busy        = (state_reg != S_IDLE);
   assign done        = done_reg;
   assign valid       = valid_reg;
   assign truth_table = table_reg;

endmodule
